// File: rtl/feed_forward_stream_tx_pkg.sv
// Shared types and helpers for the feed-forward stream transmitter.
//   DEFAULT_DATA_WIDTH : word width shared by the layer and the transmitter
//   tx_state_e         : transmitter FSM state encoding
//   idx_width()        : counter/address width, never below 1 bit
package feed_forward_stream_tx_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_GAP    = 2'd2,
        ST_DONE   = 2'd3
    } tx_state_e;

    // Width needed to index n items; a single item still gets one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/feed_forward_stream_tx_weight_ram.sv
// Simple dual-port weight RAM: one write port, one registered read port (1-cycle latency).
//   clk       : clock, rising edge
//   wr_en_i   : write enable (address already range-checked by the caller)
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_en_i   : read enable; rd_data_o updates only when set
//   rd_addr_i : read address
//   rd_data_o : registered read data
module feed_forward_stream_tx_weight_ram #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 6,
    parameter int unsigned AW    = 3
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [DW-1:0] wr_data_i,
    input  logic          rd_en_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [DW-1:0] rd_data_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rd_data_q;

    // Contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/feed_forward_stream_tx.sv
// Transmit side of the (valid, weight, data) feed-forward stream. Holds one input vector
// and a weight matrix and replays them as one burst of N_IN beats per output node.
//   clk           : clock, rising edge
//   rst_n         : asynchronous reset, ACTIVE-HIGH despite the name
//   i_data_valid  : load one input-vector word (IDLE only)
//   i_data        : input-vector word, element order 0..N_IN-1
//   i_weight_we   : weight write enable (IDLE only)
//   i_weight_addr : weight address = node*N_IN + input
//   i_weight      : weight write data
//   i_start       : start one run (pulse), accepted only while o_ready
//   o_ready       : IDLE with a full input vector
//   o_valid       : stream beat valid
//   o_weight      : stream weight
//   o_data        : stream data
//   o_node_idx    : output node of the current beat
//   o_done        : one-cycle pulse after the final beat of a run
module feed_forward_stream_tx
    import feed_forward_stream_tx_pkg::*;
#(
    parameter int unsigned DATA_WIDTH            = DEFAULT_DATA_WIDTH,
    parameter int unsigned NUMBER_OF_INPUT_NODE  = 3,
    parameter int unsigned NUMBER_OF_OUTPUT_NODE = 32,
    parameter int unsigned GAP_CYCLES            = 1
) (
    input  logic                                                   clk,
    input  logic                                                   rst_n,
    input  logic                                                   i_data_valid,
    input  logic [DATA_WIDTH-1:0]                                  i_data,
    input  logic                                                   i_weight_we,
    input  logic [idx_width(NUMBER_OF_INPUT_NODE*NUMBER_OF_OUTPUT_NODE)-1:0] i_weight_addr,
    input  logic [DATA_WIDTH-1:0]                                  i_weight,
    input  logic                                                   i_start,
    output logic                                                   o_ready,
    output logic                                                   o_valid,
    output logic [DATA_WIDTH-1:0]                                  o_weight,
    output logic [DATA_WIDTH-1:0]                                  o_data,
    output logic [idx_width(NUMBER_OF_OUTPUT_NODE)-1:0]            o_node_idx,
    output logic                                                   o_done
);

    localparam int unsigned N_IN  = NUMBER_OF_INPUT_NODE;
    localparam int unsigned N_OUT = NUMBER_OF_OUTPUT_NODE;
    localparam int unsigned DEPTH = N_IN * N_OUT;
    localparam int unsigned AW    = idx_width(DEPTH);
    localparam int unsigned KW    = idx_width(N_IN);
    localparam int unsigned NW    = idx_width(N_OUT);
    localparam int unsigned GW    = idx_width(GAP_CYCLES);
    localparam int unsigned LW    = $clog2(N_IN + 1);

    tx_state_e state_q, state_d;

    logic [KW-1:0]         k_q, k_d;
    logic [NW-1:0]         node_q, node_d;
    logic [GW-1:0]         gap_q, gap_d;
    logic [LW-1:0]         load_cnt_q, load_cnt_d;
    logic [DATA_WIDTH-1:0] buf_q [N_IN];

    // Read-stage pipeline, aligned with the registered RAM output.
    logic          vld_p_q;
    logic [KW-1:0] k_p_q;
    logic [NW-1:0] node_p_q;
    logic          done_p_q;

    logic                  ready_q, valid_q, done_q;
    logic [DATA_WIDTH-1:0] weight_q, data_q;
    logic [NW-1:0]         node_idx_q;

    logic issue_c, load_c, we_c, ready_c, done_c;
    logic last_k_c, last_node_c, gap_last_c;
    logic [AW-1:0]         rd_addr_c;
    logic [DATA_WIDTH-1:0] rd_data_c;

    assign last_k_c    = (k_q == KW'(N_IN - 1));
    assign last_node_c = (node_q == NW'(N_OUT - 1));
    assign gap_last_c  = (gap_q == GW'(GAP_CYCLES - 1));
    assign rd_addr_c   = AW'(32'(node_q) * N_IN + 32'(k_q));

    // FSM state register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start && ready_c) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (last_k_c) begin
                    if (last_node_c)          state_d = ST_DONE;
                    else if (GAP_CYCLES == 0) state_d = ST_STREAM;
                    else                      state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (gap_last_c) state_d = ST_STREAM;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM control outputs.
    always_comb begin
        issue_c = 1'b0;
        load_c  = 1'b0;
        we_c    = 1'b0;
        ready_c = 1'b0;
        done_c  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                ready_c = (load_cnt_q == LW'(N_IN));
                load_c  = i_data_valid && (load_cnt_q < LW'(N_IN));
                we_c    = i_weight_we && (32'(i_weight_addr) < DEPTH);
            end
            ST_STREAM: issue_c = 1'b1;
            ST_DONE:   done_c  = 1'b1;
            default: ;
        endcase
    end

    // Counter next-state: beat/node/gap counters wrap at their terminal values.
    always_comb begin
        k_d        = k_q;
        node_d     = node_q;
        gap_d      = gap_q;
        load_cnt_d = load_cnt_q;
        if (issue_c) begin
            k_d = last_k_c ? '0 : k_q + KW'(1);
            if (last_k_c) node_d = last_node_c ? '0 : node_q + NW'(1);
        end
        if (state_q == ST_GAP) gap_d = gap_last_c ? '0 : gap_q + GW'(1);
        if (load_c)            load_cnt_d = load_cnt_q + LW'(1);
        if (done_c)            load_cnt_d = '0;
    end

    // Counters, input buffer and read-stage pipeline.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            k_q        <= '0;
            node_q     <= '0;
            gap_q      <= '0;
            load_cnt_q <= '0;
            for (int i = 0; i < int'(N_IN); i++) buf_q[i] <= '0;
            vld_p_q    <= 1'b0;
            k_p_q      <= '0;
            node_p_q   <= '0;
            done_p_q   <= 1'b0;
        end else begin
            k_q        <= k_d;
            node_q     <= node_d;
            gap_q      <= gap_d;
            load_cnt_q <= load_cnt_d;
            if (load_c) buf_q[KW'(load_cnt_q)] <= i_data;
            vld_p_q    <= issue_c;
            k_p_q      <= k_q;
            node_p_q   <= node_q;
            done_p_q   <= done_c;
        end
    end

    // Output registers; payload is forced to zero between beats.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            weight_q   <= '0;
            data_q     <= '0;
            node_idx_q <= '0;
            done_q     <= 1'b0;
        end else begin
            ready_q    <= (state_d == ST_IDLE) && (load_cnt_d == LW'(N_IN));
            valid_q    <= vld_p_q;
            weight_q   <= vld_p_q ? rd_data_c : '0;
            data_q     <= vld_p_q ? buf_q[k_p_q] : '0;
            node_idx_q <= vld_p_q ? node_p_q : '0;
            done_q     <= done_p_q;
        end
    end

    feed_forward_stream_tx_weight_ram #(
        .DW    (DATA_WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_weight_ram (
        .clk       (clk),
        .wr_en_i   (we_c),
        .wr_addr_i (i_weight_addr),
        .wr_data_i (i_weight),
        .rd_en_i   (issue_c),
        .rd_addr_i (rd_addr_c),
        .rd_data_o (rd_data_c)
    );

    assign o_ready    = ready_q;
    assign o_valid    = valid_q;
    assign o_weight   = weight_q;
    assign o_data     = data_q;
    assign o_node_idx = node_idx_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_feed_forward_stream_tx.sv
// Directed bench for feed_forward_stream_tx with N_IN=3, N_OUT=2; one instance with
// GAP_CYCLES=1 and one with GAP_CYCLES=0, driven from the same inputs.
module tb_feed_forward_stream_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_data_valid, i_weight_we, i_start;
    logic [31:0] i_data, i_weight;
    logic [2:0]  i_weight_addr;

    logic        rdy1, vld1, dn1, rdy0, vld0, dn0;
    logic [31:0] w1, d1, w0, d0;
    logic        n1, n0;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] wm  [6];
    logic [31:0] vec [3];

    always #5 clk = ~clk;

    feed_forward_stream_tx #(
        .DATA_WIDTH(32), .NUMBER_OF_INPUT_NODE(3), .NUMBER_OF_OUTPUT_NODE(2), .GAP_CYCLES(1)
    ) dut_g1 (
        .clk(clk), .rst_n(rst_n), .i_data_valid(i_data_valid), .i_data(i_data),
        .i_weight_we(i_weight_we), .i_weight_addr(i_weight_addr), .i_weight(i_weight),
        .i_start(i_start), .o_ready(rdy1), .o_valid(vld1), .o_weight(w1), .o_data(d1),
        .o_node_idx(n1), .o_done(dn1)
    );

    feed_forward_stream_tx #(
        .DATA_WIDTH(32), .NUMBER_OF_INPUT_NODE(3), .NUMBER_OF_OUTPUT_NODE(2), .GAP_CYCLES(0)
    ) dut_g0 (
        .clk(clk), .rst_n(rst_n), .i_data_valid(i_data_valid), .i_data(i_data),
        .i_weight_we(i_weight_we), .i_weight_addr(i_weight_addr), .i_weight(i_weight),
        .i_start(i_start), .o_ready(rdy0), .o_valid(vld0), .o_weight(w0), .o_data(d0),
        .o_node_idx(n0), .o_done(dn0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    // All driving tasks are entered at a falling edge and return at a falling edge.
    task automatic wr_weight(input logic [2:0] a, input logic [31:0] v);
        i_weight_we = 1'b1; i_weight_addr = a; i_weight = v;
        @(negedge clk);
        i_weight_we = 1'b0;
    endtask

    task automatic load_word(input logic [31:0] v);
        i_data_valid = 1'b1; i_data = v;
        @(negedge clk);
        i_data_valid = 1'b0;
    endtask

    // Expected stream at cycle s after the accepted start edge, for gap length g.
    task automatic check_dut(input string tag, input int g, input int s,
                             input logic v, input logic [31:0] w, input logic [31:0] d,
                             input logic n, input logic dn);
        int  p, nd, kk;
        bit  ev;
        p  = s - 2;
        nd = 0;
        kk = 0;
        ev = 1'b0;
        if (p >= 0) begin
            nd = p / (3 + g);
            kk = p % (3 + g);
            ev = (nd < 2) && (kk < 3);
        end
        check($sformatf("%s_s%0d_valid", tag, s), 32'(v), 32'(ev));
        if (ev) begin
            check($sformatf("%s_s%0d_weight", tag, s), w, wm[nd*3+kk]);
            check($sformatf("%s_s%0d_data", tag, s), d, vec[kk]);
            check($sformatf("%s_s%0d_node", tag, s), 32'(n), 32'(nd));
        end else begin
            check($sformatf("%s_s%0d_zero", tag, s), w | d | 32'(n), 32'h0);
        end
        check($sformatf("%s_s%0d_done", tag, s), 32'(dn), 32'(s == 8 + g));
    endtask

    // Starts a run and checks both instances cycle by cycle. With inject set, a weight
    // write to address 0 and a second i_start are applied mid-stream.
    task automatic run_check(input string tag, input bit inject);
        int done1 = 0;
        int done0 = 0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int s = 0; s < 14; s++) begin
            check_dut({tag, "_g1"}, 1, s, vld1, w1, d1, n1, dn1);
            check_dut({tag, "_g0"}, 0, s, vld0, w0, d0, n0, dn0);
            if (dn1) done1++;
            if (dn0) done0++;
            if (inject && s == 3) begin
                i_weight_we = 1'b1; i_weight_addr = 3'd0; i_weight = 32'hDEAD_BEEF;
                i_start = 1'b1;
            end else begin
                i_weight_we = 1'b0;
                i_start = 1'b0;
            end
            @(negedge clk);
        end
        check({tag, "_done_count_g1"}, 32'(done1), 32'd1);
        check({tag, "_done_count_g0"}, 32'(done0), 32'd1);
        check({tag, "_ready_after"}, 32'({rdy1, rdy0}), 32'h0);
    endtask

    task automatic load_vec(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        vec[0] = a; vec[1] = b; vec[2] = c;
        load_word(a);
        load_word(b);
        load_word(c);
    endtask

    initial begin
        int dcount;
        rst_n = 1'b1;
        i_data_valid = 1'b0; i_data = '0;
        i_weight_we = 1'b0; i_weight_addr = '0; i_weight = '0;
        i_start = 1'b0;
        for (int i = 0; i < 6; i++) wm[i] = 32'h1000_0000 + 32'(i + 1);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_outputs", {28'h0, vld1, rdy1, dn1, n1}, 32'h0);
        check("rst_payload", w1 | d1, 32'h0);
        rst_n = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'({rdy1, rdy0}), 32'h0);

        // Basic run with one gap cycle
        for (int i = 0; i < 6; i++) wr_weight(3'(i), wm[i]);
        load_vec(32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003);
        check("t1_ready", 32'({rdy1, rdy0}), 32'h3);
        run_check("t1", 1'b0);

        // Start with a partial vector is ignored; a fourth word is dropped
        vec[0] = 32'h0000_00A1; vec[1] = 32'h0000_00B2; vec[2] = 32'h0000_00C3;
        load_word(vec[0]);
        load_word(vec[1]);
        check("t2_ready_partial", 32'(rdy1), 32'h0);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (3) begin
            check("t2_no_stream", 32'({vld1, vld0}), 32'h0);
            @(negedge clk);
        end
        load_word(vec[2]);
        load_word(32'hFFFF_FFFF);
        check("t2_ready_full", 32'(rdy1), 32'h1);
        run_check("t2", 1'b0);

        // Mid-run weight write and second start are both ignored
        load_vec(32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F);
        run_check("t3", 1'b1);

        // Reset during the fourth beat aborts the stream immediately
        load_vec(32'h5555_0001, 32'h5555_0002, 32'h5555_0003);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        repeat (6) @(negedge clk);
        check("t4_beat4_valid", 32'(vld1), 32'h1);
        check("t4_beat4_weight", w1, wm[3]);
        rst_n = 1'b1;
        #1;
        check("t4_abort_valid", 32'({vld1, vld0}), 32'h0);
        check("t4_abort_payload", w1 | d1 | w0 | d0, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        dcount = 0;
        repeat (8) begin
            @(negedge clk);
            if (dn1 || dn0) dcount++;
        end
        check("t4_no_done", 32'(dcount), 32'h0);
        check("t4_ready_after_rst", 32'({rdy1, rdy0}), 32'h0);
        load_vec(32'h7777_0001, 32'h7777_0002, 32'h7777_0003);
        run_check("t4", 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
